// File: rtl/npc_seq_pkg.sv
// Shared types and constants for the NPC multi-cycle instruction sequencer.
package npc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_MDU  = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ILL   = 2'b01;
  localparam logic [1:0] ERR_MEMTO = 2'b10;

  typedef struct packed {
    logic ld;
    logic st;
    logic mdu;
    logic trap;
    logic ill;
    logic rf_req;
    logic c_req;
  } flags_t;

  // One spare bit beyond the larger limit so the count never aliases.
  function automatic int timer_w(input int mem_to, input int mdu_lat);
    int m;
    m = (mem_to > mdu_lat) ? mem_to : mdu_lat;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/inst_seq_timer.sv
// Wait-state up-counter shared by MEM and MDU; hit marks the last allowed cycle.
module seq_timer
  import npc_seq_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear before a wait state, advance while inside one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && (cnt_q == lim_i);

endmodule

// File: rtl/inst_seq.sv
// Multi-cycle instruction sequencer: issue, EXEC, optional MEM/MDU wait, commit or error.
module inst_seq
  import npc_seq_pkg::*;
#(
  parameter int MDU_FIXED   = 0,
  parameter int MDU_LAT     = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_mdu,
  input  logic             is_trap,
  input  logic             is_illegal,
  input  logic             rf_wen_req,
  input  logic             c_wen_req,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             mdu_start,
  input  logic             mdu_done,
  output logic             rf_wen,
  output logic             c_wen,
  output logic             trap_wen,
  output logic             pc_we,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = timer_w(MEM_TIMEOUT, MDU_LAT);
  localparam logic [TW-1:0] MEM_LIM = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0] MDU_LIM = TW'(MDU_LAT - 1);

  state_e             state_q;
  state_e             state_d;
  flags_t             flags_q;
  flags_t             flags_d;
  logic [CNT_W-1:0]   instret_q;
  logic               tmr_hit;
  logic               tmr_en;
  logic [TW-1:0]      tmr_lim;
  logic               mdu_leave;

  assign tmr_en  = (state_q == ST_MEM) || (state_q == ST_MDU);
  assign tmr_lim = (state_q == ST_MDU) ? MDU_LIM : MEM_LIM;

  seq_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == ST_EXEC),
    .en_i  (tmr_en),
    .lim_i (tmr_lim),
    .hit_o (tmr_hit)
  );

  assign mdu_leave = (MDU_FIXED != 0) ? tmr_hit : mdu_done;

  // Next-state logic; in MEM an ack wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid) begin
          state_d = is_illegal ? ST_ERR : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (flags_q.trap) begin
          state_d = ST_WB;
        end else if (flags_q.ld || flags_q.st) begin
          state_d = ST_MEM;
        end else if (flags_q.mdu) begin
          state_d = ST_MDU;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_WB;
        end else if (tmr_hit) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MDU: begin
        if (mdu_leave) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MDU;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoder flags are captured only at accept.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == ST_IDLE) && inst_valid) begin
      flags_d = '{ld: is_load, st: is_store, mdu: is_mdu, trap: is_trap,
                  ill: is_illegal, rf_req: rf_wen_req, c_req: c_wen_req};
    end else begin
      flags_d = flags_q;
    end
  end

  // State, flag and retire-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      flags_q   <= '0;
      instret_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (state_q == ST_WB) begin
        instret_q <= instret_q + CNT_W'(1);
      end else begin
        instret_q <= instret_q;
      end
    end
  end

  assign inst_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_req    = (state_q == ST_MEM);
  assign mem_we     = (state_q == ST_MEM) && flags_q.st;
  assign mdu_start  = (state_q == ST_EXEC) && !flags_q.trap && !flags_q.ld &&
                      !flags_q.st && flags_q.mdu;
  assign pc_we      = (state_q == ST_WB);
  assign rf_wen     = (state_q == ST_WB) && flags_q.rf_req && !flags_q.trap;
  assign c_wen      = (state_q == ST_WB) && flags_q.c_req && !flags_q.trap;
  assign trap_wen   = (state_q == ST_WB) && flags_q.trap;
  assign err        = (state_q == ST_ERR);
  assign err_code   = (state_q != ST_ERR) ? ERR_NONE :
                      (flags_q.ill ? ERR_ILL : ERR_MEMTO);
  assign instret    = instret_q;

endmodule

// File: tb/tb_inst_seq.sv
// Directed bench for inst_seq: cycle table on a timeout-4 / mdu_done instance, fixed-latency MDU on a second.
module tb_inst_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0, v1, ld, st, md, tr, il, rfq, cq, ack, done;

  logic rdy0, mreq0, mwe0, ms0, rfw0, cw0, tw0, pcw0, er0, bsy0;
  logic [1:0] ec0;
  logic [7:0] cnt0;
  logic rdy1, mreq1, mwe1, ms1, rfw1, cw1, tw1, pcw1, er1, bsy1;
  logic [1:0] ec1;
  logic [3:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_seq #(.MDU_FIXED(0), .MDU_LAT(8), .MEM_TIMEOUT(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .inst_valid(v0), .inst_ready(rdy0),
    .is_load(ld), .is_store(st), .is_mdu(md), .is_trap(tr), .is_illegal(il),
    .rf_wen_req(rfq), .c_wen_req(cq), .mem_req(mreq0), .mem_we(mwe0), .mem_ack(ack),
    .mdu_start(ms0), .mdu_done(done), .rf_wen(rfw0), .c_wen(cw0), .trap_wen(tw0),
    .pc_we(pcw0), .err(er0), .err_code(ec0), .busy(bsy0), .instret(cnt0));

  inst_seq #(.MDU_FIXED(1), .MDU_LAT(8), .MEM_TIMEOUT(255), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .inst_valid(v1), .inst_ready(rdy1),
    .is_load(ld), .is_store(st), .is_mdu(md), .is_trap(tr), .is_illegal(il),
    .rf_wen_req(rfq), .c_wen_req(cq), .mem_req(mreq1), .mem_we(mwe1), .mem_ack(ack),
    .mdu_start(ms1), .mdu_done(done), .rf_wen(rfw1), .c_wen(cw1), .trap_wen(tw1),
    .pc_we(pcw1), .err(er1), .err_code(ec1), .busy(bsy1), .instret(cnt1));

  // inputs: valid load store mdu trap ill rf_req c_req ack done
  localparam logic [9:0] I_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] I_ADD   = 10'b10_0000_1000;
  localparam logic [9:0] I_ADDC  = 10'b10_0000_1100;
  localparam logic [9:0] I_LOAD  = 10'b11_0000_1000;
  localparam logic [9:0] I_STORE = 10'b10_1000_0000;
  localparam logic [9:0] I_ILL   = 10'b10_0001_1000;
  localparam logic [9:0] I_ILL2  = 10'b10_0001_0000;
  localparam logic [9:0] I_MDU   = 10'b10_0100_1000;
  localparam logic [9:0] I_TRAP  = 10'b11_0010_1100;
  localparam logic [9:0] I_ACK   = 10'b00_0000_0010;
  localparam logic [9:0] I_DONE  = 10'b00_0000_0001;
  localparam logic [9:0] I_BOTH  = 10'b00_0000_0011;

  // outputs: ready busy mem_req mem_we mdu_start rf_wen c_wen trap_wen pc_we err code[1:0]
  localparam logic [11:0] O_IDLE  = 12'b1000_0000_0000;
  localparam logic [11:0] O_EXEC  = 12'b0100_0000_0000;
  localparam logic [11:0] O_EXMD  = 12'b0100_1000_0000;
  localparam logic [11:0] O_MEML  = 12'b0110_0000_0000;
  localparam logic [11:0] O_MEMS  = 12'b0111_0000_0000;
  localparam logic [11:0] O_WBRF  = 12'b0100_0100_1000;
  localparam logic [11:0] O_WBPC  = 12'b0100_0000_1000;
  localparam logic [11:0] O_WBTR  = 12'b0100_0001_1000;
  localparam logic [11:0] O_WBRC  = 12'b0100_0110_1000;
  localparam logic [11:0] O_ERIL  = 12'b0100_0000_0101;
  localparam logic [11:0] O_ERTO  = 12'b0100_0000_0110;

  typedef struct {
    logic [9:0]  in;
    logic [11:0] exp;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[36];

  function automatic logic [11:0] outs0();
    return {rdy0, bsy0, mreq0, mwe0, ms0, rfw0, cw0, tw0, pcw0, er0, ec0};
  endfunction

  task automatic drive(input logic [9:0] v, input logic to1);
    v0   = to1 ? 1'b0 : v[9];
    v1   = to1 ? v[9] : 1'b0;
    ld   = v[8]; st = v[7]; md = v[6]; tr = v[5]; il = v[4];
    rfq  = v[3]; cq = v[2]; ack = v[1]; done = v[0];
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{I_ADD,   O_IDLE, 8'd0};
    tbl[1]  = '{I_NONE,  O_EXEC, 8'd0};
    tbl[2]  = '{I_NONE,  O_WBRF, 8'd0};
    tbl[3]  = '{I_LOAD,  O_IDLE, 8'd1};
    tbl[4]  = '{I_NONE,  O_EXEC, 8'd1};
    tbl[5]  = '{I_NONE,  O_MEML, 8'd1};
    tbl[6]  = '{I_NONE,  O_MEML, 8'd1};
    tbl[7]  = '{I_ACK,   O_MEML, 8'd1};
    tbl[8]  = '{I_NONE,  O_WBRF, 8'd1};
    tbl[9]  = '{I_STORE, O_IDLE, 8'd2};
    tbl[10] = '{I_NONE,  O_EXEC, 8'd2};
    tbl[11] = '{I_ACK,   O_MEMS, 8'd2};
    tbl[12] = '{I_NONE,  O_WBPC, 8'd2};
    tbl[13] = '{I_BOTH,  O_IDLE, 8'd3};
    tbl[14] = '{I_LOAD,  O_IDLE, 8'd3};
    tbl[15] = '{I_NONE,  O_EXEC, 8'd3};
    tbl[16] = '{I_NONE,  O_MEML, 8'd3};
    tbl[17] = '{I_NONE,  O_MEML, 8'd3};
    tbl[18] = '{I_NONE,  O_MEML, 8'd3};
    tbl[19] = '{I_NONE,  O_MEML, 8'd3};
    tbl[20] = '{I_NONE,  O_ERTO, 8'd3};
    tbl[21] = '{I_ILL,   O_IDLE, 8'd3};
    tbl[22] = '{I_NONE,  O_ERIL, 8'd3};
    tbl[23] = '{I_MDU,   O_IDLE, 8'd3};
    tbl[24] = '{I_DONE,  O_EXMD, 8'd3};
    tbl[25] = '{I_NONE,  O_EXEC, 8'd3};
    tbl[26] = '{I_NONE,  O_EXEC, 8'd3};
    tbl[27] = '{I_DONE,  O_EXEC, 8'd3};
    tbl[28] = '{I_NONE,  O_WBRF, 8'd3};
    tbl[29] = '{I_TRAP,  O_IDLE, 8'd4};
    tbl[30] = '{I_NONE,  O_EXEC, 8'd4};
    tbl[31] = '{I_ADDC,  O_WBTR, 8'd4};
    tbl[32] = '{I_ADDC,  O_IDLE, 8'd5};
    tbl[33] = '{I_ILL2,  O_EXEC, 8'd5};
    tbl[34] = '{I_NONE,  O_WBRC, 8'd5};
    tbl[35] = '{I_NONE,  O_IDLE, 8'd6};

    drive(I_NONE, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_outs0", 32'(outs0()), 32'(O_IDLE));
    chk("reset_cnt0", 32'(cnt0), 32'd0);
    chk("reset_rdy1", 32'(rdy1), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      drive(tbl[i].in, 1'b0);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs0()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_instret", i), 32'(cnt0), 32'(tbl[i].cnt));
    end

    // Asynchronous reset while a load is waiting in MEM; a late ack must not matter.
    @(negedge clk); drive(I_LOAD, 1'b0);
    @(negedge clk); drive(I_NONE, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("midmem_req_before", 32'(mreq0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midmem_req_reset", 32'(mreq0), 32'd0);
    chk("midmem_rdy_reset", 32'(rdy0), 32'd1);
    chk("midmem_cnt_reset", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(I_ACK, 1'b0);
    @(negedge clk); drive(I_NONE, 1'b0);
    @(negedge clk); #1;
    chk("late_ack_outs", 32'(outs0()), 32'(O_IDLE));
    chk("late_ack_cnt", 32'(cnt0), 32'd0);

    // Fixed-latency MDU: start pulse at T+1, commit at T+10.
    @(negedge clk); drive(I_MDU, 1'b1); #1;
    chk("fix_accept_rdy", 32'(rdy1), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); drive(I_NONE, 1'b1); #1;
      chk($sformatf("fix_t%0d_start", k), 32'(ms1), 32'(k == 1));
      chk($sformatf("fix_t%0d_pcwe", k), 32'(pcw1), 32'(k == 10));
      chk($sformatf("fix_t%0d_rfwen", k), 32'(rfw1), 32'(k == 10));
    end
    chk("fix_instret", 32'(cnt1), 32'd1);

    // Fifteen more commits wrap the 4-bit counter back to zero.
    for (int n = 0; n < 15; n++) begin
      @(negedge clk); drive(I_ADD, 1'b1);
      @(negedge clk); drive(I_NONE, 1'b1);
      @(negedge clk);
    end
    @(negedge clk); #1;
    chk("wrap_instret", 32'(cnt1), 32'd0);
    chk("wrap_rdy", 32'(rdy1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_seq.md
# inst_seq

Multi-cycle instruction sequencer for the NPC core. It sits between the combinational decoder and the datapath. It latches the decoder's per-instruction class flags at issue and walks each instruction through EXEC, optional memory or multiply/divide wait, and write-back. Register-file and CSR write enables and the PC update are gated to a single commit cycle, memory stalls time out into an error, and retired instructions are counted.

## Interface
Parameters:
- MDU_FIXED, 0: 0 = MDU completion by `mdu_done`; 1 = fixed latency of MDU_LAT cycles, `mdu_done` ignored
- MDU_LAT, 8: fixed MDU latency in cycles, ≥1
- MEM_TIMEOUT, 255: maximum MEM-state cycles before error, ≥1
- CNT_W, 64: width of the retired-instruction counter

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst_valid  in  1  decoded instruction available
- inst_ready  out  1  sequencer accepts an instruction this cycle
- is_load, is_store, is_mdu, is_trap, is_illegal  in  1 each  decoder class flags, sampled at accept
- rf_wen_req, c_wen_req  in  1 each  decoder write intents, sampled at accept
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  request is a store
- mem_ack  in  1  memory done (mem_finish)
- mdu_start  out  1  one-cycle MDU launch pulse
- mdu_done  in  1  MDU result valid
- rf_wen, c_wen  out  1 each  commit-gated write enables
- trap_wen  out  1  trap CSR update (mepc/mcause) at commit
- pc_we  out  1  PC register update at commit
- err  out  1  one-cycle error pulse
- err_code  out  2  01 illegal, 10 memory timeout; 00 otherwise
- busy  out  1  state ≠ IDLE
- instret  out  CNT_W  count of committed instructions

## Operation
- States: IDLE, EXEC, MEM, MDU, WB, ERR. Outputs are Moore, decoded from the state register and the latched flags only.
- IDLE:
  - inst_ready=1.
  - If inst_valid: latch all flags. Go to ERR if is_illegal, else go to EXEC.
- EXEC:
  - Priority: is_trap → WB; load|store → MEM; is_mdu → MDU (mdu_start=1 in EXEC); else → WB.
- MEM:
  - mem_req=1; mem_we=latched is_store.
  - Timer counts MEM cycles. If mem_ack → WB; otherwise, if count reaches MEM_TIMEOUT → ERR with code 10.
  - mem_ack on the first MEM cycle is legal. mem_ack and expiry in the same cycle resolve to WB.
- MDU:
  - MDU_FIXED=0: leave on mdu_done.
  - MDU_FIXED=1: leave after MDU_LAT cycles in MDU.
  - Next state WB.
- WB:
  - pc_we=1; rf_wen=latched rf_wen_req & ~is_trap; c_wen=latched c_wen_req & ~is_trap; trap_wen=latched is_trap.
  - instret increments by 1. Next state IDLE.
- ERR:
  - err=1 and err_code valid for one cycle.
  - No rf_wen, c_wen, trap_wen or pc_we; instret unchanged. Next state IDLE.
- mem_ack outside MEM and mdu_done outside MDU are ignored.
- Flag changes after accept have no effect.
- instret wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous assert):
  - State → IDLE; timer and instret → 0; latched flags → 0.
  - All outputs 0 except inst_ready=1. err_code=00.
  - mem_req drops in the reset cycle; a pending mem_ack after reset is ignored.
- Simple instruction: accept at cycle T, EXEC at T+1, WB at T+2, next accept possible at T+3.
- Load/store: WB occurs the cycle after mem_ack. Minimum accept-to-accept interval is 4 cycles.
- MDU fixed mode: accept-to-WB takes MDU_LAT+2 cycles.
- Timeout: ERR is entered after exactly MEM_TIMEOUT MEM cycles without ack.
- Commit strobes (pc_we, rf_wen, c_wen, trap_wen) are high for exactly one cycle per instruction.

## Structure
- Package `npc_seq_pkg`:
  - state enum (IDLE, EXEC, MEM, MDU, WB, ERR)
  - err_code constants (ERR_NONE, ERR_ILL, ERR_MEMTO)
  - timer width function: clog2 of max(MEM_TIMEOUT, MDU_LAT) plus 1
- Sub-module `seq_timer`: shared up-counter.
  - Cleared on entry to MEM or MDU.
  - Compare output `hit` against a selected limit (MEM_TIMEOUT or MDU_LAT).
  - Reused by both wait states, since they are mutually exclusive.

## Test plan
- Reset mid-MEM (mem_req=1, timer=5): deassert rst_n → same cycle mem_req=0, inst_ready=1, instret=0; a later mem_ack is ignored.
- ADD-class instruction (rf_wen_req=1, all class flags 0): accept at T → rf_wen=1 and pc_we=1 only at T+2, instret 0→1, inst_ready high again at T+3.
- Load with mem_ack after 3 MEM cycles → mem_req high for exactly 3 cycles, mem_we=0, then WB; store variant → mem_we=1 throughout MEM.
- MEM_TIMEOUT=4, no ack → err=1 with err_code=10 after 4 MEM cycles; no rf_wen, no pc_we; instret unchanged.
- MDU_FIXED=1, MDU_LAT=8 → mdu_start pulse at T+1, WB at T+10; with MDU_FIXED=0, mdu_done at the 3rd MDU cycle → WB the next cycle.
- Two cases:
  - is_illegal at accept → ERR with err_code=01 and no commit strobes.
  - is_trap with rf_wen_req=1 → trap_wen=1 and pc_we=1 at WB, rf_wen=0; back-to-back issue resumes.
